// File: rtl/multicycle_ctrl.sv
// Multicycle CPU control FSM: fetch/decode/exec/mem/wb sequencing with memory-wait timeout.
// Define MULTICYCLE_CTRL_JUMP_EN to make opcode 000010 (j) a legal single-EXEC jump.
module multicycle_ctrl #(
    parameter int unsigned ALUOP_W = 3,
    parameter int unsigned TMO_W   = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic [5:0]         instr_op_i,
    input  logic               mem_ready_i,
    output logic               PCWrite_o,
    output logic               IRWrite_o,
    output logic               Branch_o,
    output logic               Jump_o,
    output logic               MemRead_o,
    output logic               MemWrite_o,
    output logic               MemtoReg_o,
    output logic               ALUSrc_o,
    output logic               RegWrite_o,
    output logic               RegDst_o,
    output logic [ALUOP_W-1:0] ALU_op_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               err_o,
    output logic [2:0]         state_o
);

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StFetch  = 3'd1,
        StDecode = 3'd2,
        StExec   = 3'd3,
        StMem    = 3'd4,
        StWb     = 3'd5,
        StErr    = 3'd6
    } state_e;

    localparam logic [5:0] OpR    = 6'b000000;
    localparam logic [5:0] OpAddi = 6'b001000;
    localparam logic [5:0] OpAndi = 6'b001100;
    localparam logic [5:0] OpSlti = 6'b001010;
    localparam logic [5:0] OpLw   = 6'b100011;
    localparam logic [5:0] OpSw   = 6'b101011;
    localparam logic [5:0] OpBeq  = 6'b000100;
    localparam logic [5:0] OpJ    = 6'b000010;

    // Last count value that may still wait; one more idle cycle would reach 2^TMO_W-1.
    localparam logic [TMO_W-1:0] TmoLast = TMO_W'((2 ** TMO_W) - 2);

    state_e           state_q, state_d;
    logic [5:0]       op_q, op_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;

    logic is_r, is_lw, is_sw, is_beq, is_imm, is_jump, op_legal, tmo_expire;
    logic [2:0] alu_cls;

    assign is_r    = (op_q == OpR);
    assign is_lw   = (op_q == OpLw);
    assign is_sw   = (op_q == OpSw);
    assign is_beq  = (op_q == OpBeq);
    assign is_imm  = (op_q == OpAddi) || (op_q == OpAndi) || (op_q == OpSlti) || is_lw || is_sw;
    assign tmo_expire = !mem_ready_i && (tmo_q == TmoLast);

`ifdef MULTICYCLE_CTRL_JUMP_EN
    assign is_jump = (op_q == OpJ);
`else
    assign is_jump = 1'b0;
`endif

    always_comb begin
        unique case (instr_op_i)
            OpR, OpAddi, OpAndi, OpSlti, OpLw, OpSw, OpBeq: op_legal = 1'b1;
`ifdef MULTICYCLE_CTRL_JUMP_EN
            OpJ:     op_legal = 1'b1;
`endif
            default: op_legal = 1'b0;
        endcase
    end

    always_comb begin
        unique case (op_q)
            OpR:     alu_cls = 3'b010;
            OpBeq:   alu_cls = 3'b001;
            OpAndi:  alu_cls = 3'b011;
            OpSlti:  alu_cls = 3'b100;
            default: alu_cls = 3'b000;
        endcase
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        tmo_d   = tmo_q;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d = StFetch;
                    tmo_d   = '0;
                end
            end
            StFetch: begin
                if (mem_ready_i) begin
                    state_d = StDecode;
                end else if (tmo_expire) begin
                    state_d = StErr;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            StDecode: begin
                op_d    = instr_op_i;
                state_d = op_legal ? StExec : StErr;
            end
            StExec: begin
                if (is_beq || is_jump) begin
                    state_d = StIdle;
                end else if (is_lw || is_sw) begin
                    state_d = StMem;
                    tmo_d   = '0;
                end else begin
                    state_d = StWb;
                end
            end
            StMem: begin
                if (mem_ready_i) begin
                    state_d = is_lw ? StWb : StIdle;
                end else if (tmo_expire) begin
                    state_d = StErr;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            StWb:    state_d = StIdle;
            StErr:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            op_q    <= '0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            tmo_q   <= tmo_d;
        end
    end

    // Outputs are decoded from state plus same-cycle mem_ready_i; forced low while in reset.
    always_comb begin
        PCWrite_o  = 1'b0;
        IRWrite_o  = 1'b0;
        Branch_o   = 1'b0;
        Jump_o     = 1'b0;
        MemRead_o  = 1'b0;
        MemWrite_o = 1'b0;
        MemtoReg_o = 1'b0;
        ALUSrc_o   = 1'b0;
        RegWrite_o = 1'b0;
        RegDst_o   = 1'b0;
        ALU_op_o   = '0;
        busy_o     = 1'b0;
        done_o     = 1'b0;
        err_o      = 1'b0;
        state_o    = 3'd0;
        if (!rst_i) begin
            state_o = state_q;
            busy_o  = (state_q != StIdle);
            unique case (state_q)
                StFetch: begin
                    MemRead_o = 1'b1;
                    IRWrite_o = mem_ready_i;
                    PCWrite_o = mem_ready_i;
                end
                StExec: begin
                    ALU_op_o[2:0] = alu_cls;
                    ALUSrc_o      = is_imm;
                    Branch_o      = is_beq;
                    Jump_o        = is_jump;
                    PCWrite_o     = is_jump;
                    done_o        = is_beq || is_jump;
                end
                StMem: begin
                    ALU_op_o[2:0] = alu_cls;
                    ALUSrc_o      = is_imm;
                    MemRead_o     = is_lw;
                    MemWrite_o    = is_sw;
                    done_o        = is_sw && mem_ready_i;
                end
                StWb: begin
                    ALU_op_o[2:0] = alu_cls;
                    ALUSrc_o      = is_imm;
                    RegWrite_o    = 1'b1;
                    MemtoReg_o    = is_lw;
                    RegDst_o      = is_r;
                    done_o        = 1'b1;
                end
                StErr:   err_o = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench for multicycle_ctrl: builds an expected per-cycle trace from the instruction
// rules (opcode class, memory wait lengths, timeouts, resets) and compares every cycle.
module tb_multicycle_ctrl;

    localparam int TMO = 15;  // 2^TMO_W - 1 with the default TMO_W of 4

    typedef struct packed {
        logic [2:0] st;
        logic busy, done, err, pcw, irw, br, jmp, mr, mw, m2r, asrc, rw, rd;
        logic [2:0] alu;
    } exp_t;

    typedef struct packed {
        logic       rst, start, rdy;
        logic [5:0] op;
        exp_t       e;
    } step_t;

    logic clk = 1'b0;
    logic rst_i = 1'b1, start_i = 1'b0, mem_ready_i = 1'b0;
    logic [5:0] instr_op_i = '0;
    logic PCWrite_o, IRWrite_o, Branch_o, Jump_o, MemRead_o, MemWrite_o, MemtoReg_o;
    logic ALUSrc_o, RegWrite_o, RegDst_o, busy_o, done_o, err_o;
    logic [2:0] ALU_op_o, state_o;

    multicycle_ctrl dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .instr_op_i(instr_op_i),
        .mem_ready_i(mem_ready_i), .PCWrite_o(PCWrite_o), .IRWrite_o(IRWrite_o),
        .Branch_o(Branch_o), .Jump_o(Jump_o), .MemRead_o(MemRead_o), .MemWrite_o(MemWrite_o),
        .MemtoReg_o(MemtoReg_o), .ALUSrc_o(ALUSrc_o), .RegWrite_o(RegWrite_o),
        .RegDst_o(RegDst_o), .ALU_op_o(ALU_op_o), .busy_o(busy_o), .done_o(done_o),
        .err_o(err_o), .state_o(state_o)
    );

    always #5 clk = ~clk;

    step_t trace[$];
    step_t cur;
    bit    chk_en = 1'b0;
    int    n_chk = 0, n_pass = 0, cyc = 0;

`ifdef MULTICYCLE_CTRL_JUMP_EN
    localparam bit JumpEn = 1'b1;
`else
    localparam bit JumpEn = 1'b0;
`endif

    function automatic bit legal(input logic [5:0] op);
        case (op)
            6'b000000, 6'b001000, 6'b001100, 6'b001010,
            6'b100011, 6'b101011, 6'b000100: return 1'b1;
            6'b000010: return JumpEn;
            default:   return 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] alu_of(input logic [5:0] op);
        case (op)
            6'b000000: return 3'b010;
            6'b000100: return 3'b001;
            6'b001100: return 3'b011;
            6'b001010: return 3'b100;
            default:   return 3'b000;
        endcase
    endfunction

    function automatic bit imm_of(input logic [5:0] op);
        return op inside {6'b001000, 6'b001100, 6'b001010, 6'b100011, 6'b101011};
    endfunction

    function automatic exp_t base(input int st);
        exp_t e = '0;
        e.st   = 3'(st);
        e.busy = (st != 0);
        return e;
    endfunction

    task automatic add(input bit rst, input bit start, input bit rdy, input logic [5:0] op,
                       input exp_t e);
        step_t s;
        s.rst = rst; s.start = start; s.rdy = rdy; s.op = op; s.e = e;
        trace.push_back(s);
    endtask

    function automatic bit rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [5:0] rop();
        return 6'($urandom);
    endfunction

    // Appends a memory wait phase; returns 1 if it ended in a timeout.
    task automatic mem_wait(input int w, input exp_t e, output bit timed_out);
        for (int i = 0; i < w && i < TMO; i++) add(0, rb(), 0, rop(), e);
        timed_out = (w >= TMO);
        if (timed_out) begin
            exp_t x = base(6);
            x.err = 1'b1;
            add(0, rb(), rb(), rop(), x);
        end
    endtask

    task automatic gen_instr(input logic [5:0] op, input int fw, input int mw);
        exp_t e, m;
        bit   to;
        bit   is_lw = (op == 6'b100011);
        bit   is_sw = (op == 6'b101011);
        add(0, 1, rb(), rop(), base(0));
        e = base(1); e.mr = 1'b1;
        mem_wait(fw, e, to);
        if (to) return;
        e.irw = 1'b1; e.pcw = 1'b1;
        add(0, rb(), 1, rop(), e);
        add(0, rb(), rb(), op, base(2));
        if (!legal(op)) begin
            e = base(6); e.err = 1'b1;
            add(0, rb(), rb(), rop(), e);
            return;
        end
        e = base(3); e.alu = alu_of(op); e.asrc = imm_of(op);
        if (op == 6'b000100 || op == 6'b000010) begin
            e.br   = (op == 6'b000100);
            e.jmp  = (op == 6'b000010);
            e.pcw  = (op == 6'b000010);
            e.done = 1'b1;
            add(0, rb(), rb(), rop(), e);
            return;
        end
        add(0, rb(), rb(), rop(), e);
        if (is_lw || is_sw) begin
            m = base(4); m.alu = alu_of(op); m.asrc = 1'b1; m.mr = is_lw; m.mw = is_sw;
            mem_wait(mw, m, to);
            if (to) return;
            m.done = is_sw;
            add(0, rb(), 1, rop(), m);
            if (is_sw) return;
        end
        e = base(5); e.alu = alu_of(op); e.asrc = imm_of(op);
        e.rw = 1'b1; e.m2r = is_lw; e.rd = (op == 6'b000000); e.done = 1'b1;
        add(0, rb(), rb(), rop(), e);
    endtask

    // Cut the trace at index cut and replace the rest with a reset followed by an idle cycle.
    task automatic reset_at(input int cut);
        while (trace.size() > cut) void'(trace.pop_back());
        add(1, rb(), rb(), rop(), base(0));
        add(0, 0, rb(), rop(), base(0));
    endtask

    task automatic pin(input string name, input int got, input int req);
        n_chk++;
        if (got == req) n_pass++;
        else $display("FAIL model %s: got %0d required %0d", name, got, req);
    endtask

    function automatic int rwait();
        int r = $urandom_range(0, 9);
        if (r < 6) return 0;
        if (r < 8) return $urandom_range(1, 3);
        if (r == 8) return TMO - 1;
        return $urandom_range(TMO, TMO + 2);
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            exp_t got;
            got = {state_o, busy_o, done_o, err_o, PCWrite_o, IRWrite_o, Branch_o, Jump_o,
                   MemRead_o, MemWrite_o, MemtoReg_o, ALUSrc_o, RegWrite_o, RegDst_o, ALU_op_o};
            n_chk++;
            if (got === cur.e) n_pass++;
            else $display("FAIL outputs cycle %0d: got %h required %h (st got %0d req %0d)",
                          cyc, got, cur.e, state_o, cur.e.st);
        end
    end

    initial begin
        int n0, cnt, sum;
        logic [5:0] ops[8];
        ops = '{6'b000000, 6'b001000, 6'b001100, 6'b001010,
                6'b100011, 6'b101011, 6'b000100, 6'b000010};

        add(1, 1, 1, rop(), base(0));
        add(1, 0, 0, rop(), base(0));
        add(0, 0, rb(), rop(), base(0));

        // R-type with immediate memory: IDLE then states 1,2,3,5.
        n0 = trace.size(); gen_instr(6'b000000, 0, 0);
        pin("r_len", trace.size() - n0, 5);
        sum = 0;
        for (int i = n0; i < trace.size(); i++) sum = sum * 10 + int'(trace[i].e.st);
        pin("r_states", sum, 1235);
        pin("r_wb_alu", int'(trace[n0 + 4].e.alu), 2);

        // lw with three not-ready MEM cycles: 8 cycles after start, MemRead held 4.
        n0 = trace.size(); gen_instr(6'b100011, 0, 3);
        pin("lw_len", trace.size() - n0 - 1, 8);
        cnt = 0;
        for (int i = n0; i < trace.size(); i++) if (trace[i].e.st == 3'd4 && trace[i].e.mr) cnt++;
        pin("lw_memread", cnt, 4);
        pin("lw_m2r", int'(trace[trace.size() - 1].e.m2r), 1);

        // sw finishes in MEM; no WB.
        n0 = trace.size(); gen_instr(6'b101011, 0, 1);
        pin("sw_last_st", int'(trace[trace.size() - 1].e.st), 4);
        pin("sw_done", int'(trace[trace.size() - 1].e.done), 1);

        n0 = trace.size(); gen_instr(6'b000100, 0, 0);
        pin("beq_len", trace.size() - n0, 4);
        n0 = trace.size(); gen_instr(6'b111111, 0, 0);
        pin("ill_err", int'(trace[trace.size() - 1].e.err), 1);

        // Fetch timeout vs. ready arriving on the 15th fetch cycle.
        n0 = trace.size(); gen_instr(6'b000000, TMO, 0);
        pin("tmo_len", trace.size() - n0, 17);
        n0 = trace.size(); gen_instr(6'b000000, TMO - 1, 0);
        pin("tmo_rescue", int'(trace[n0 + 16].e.st), 2);

        // Reset in the middle of MEM, then jump (legal only with the macro).
        n0 = trace.size(); gen_instr(6'b100011, 0, 5);
        reset_at(n0 + 6);
        n0 = trace.size(); gen_instr(6'b000010, 0, 0);
        pin("j_last_done", int'(trace[trace.size() - 1].e.done), int'(JumpEn));

        for (int k = 0; k < 300; k++) begin
            logic [5:0] op = ($urandom_range(0, 4) == 0) ? rop() : ops[$urandom_range(0, 7)];
            if ($urandom_range(0, 3) == 0) add(0, 0, rb(), rop(), base(0));
            n0 = trace.size();
            gen_instr(op, rwait(), rwait());
            if ($urandom_range(0, 11) == 0) reset_at($urandom_range(n0 + 1, trace.size() - 1));
        end

        foreach (trace[i]) begin
            @(posedge clk);
            #1;
            cur         = trace[i];
            cyc         = i;
            rst_i       = cur.rst;
            start_i     = cur.start;
            mem_ready_i = cur.rdy;
            instr_op_i  = cur.op;
            chk_en      = 1'b1;
        end
        @(posedge clk);
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
